logic_gates_sweeper: RTL and testbench

Self-test sequencer for the ten-output two-input gate bank. On a start request it drives the gate bank's `a`/`b` inputs through all four input vectors and captures the 10-bit `y` response for each vector. It compares each response against internally computed golden values and reports a sticky per-gate fail mask and a pass flag with a done pulse. The sweeper sits beside the gate bank as its only driver and is used for bring-up and power-on self-test.

---
 rtl/logic_gates_sweeper.sv | 175 +++++++++++++++++
 tb/tb_logic_gates_sweeper.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_gates_sweeper.sv
// Self-test sequencer for the ten-output two-input gate bank.
// Optional saturating mismatch counter: define LOGIC_GATES_SWEEP_ERRCNT_EN.
module logic_gates_sweeper #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  y,
    output logic        a,
    output logic        b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [9:0]  fail_mask,
    output logic [39:0] truth_table,
    output logic [1:0]  vec_idx
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_a;
    logic        r_b;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [9:0]  r_fail_mask;
    logic [39:0] r_truth_table;
    logic [1:0]  r_vec_idx;
    logic [3:0]  r_hold_cnt;
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
    logic [7:0]  r_err_cnt;
`endif

    logic [9:0]  w_golden;
    logic [9:0]  w_diff;
    logic [1:0]  w_next_vec;
    logic        w_hold_last;

    // Expected bank response, bit order AND, OR, XOR, NAND, NOR, XNOR, ~a, ~b, a, b.
    function automatic logic [9:0] golden(input logic [1:0] v);
        logic ga;
        logic gb;
        ga = v[1];
        gb = v[0];
        return {gb, ga, ~gb, ~ga, ~(ga ^ gb), ~(ga | gb), ~(ga & gb),
                ga ^ gb, ga | gb, ga & gb};
    endfunction

    assign w_golden    = golden(r_vec_idx);
    assign w_diff      = y ^ w_golden;
    assign w_next_vec  = r_vec_idx + 2'd1;
    assign w_hold_last = (r_hold_cnt == 4'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_mask   <= '0;
            r_truth_table <= '0;
            r_vec_idx     <= '0;
            r_hold_cnt    <= '0;
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
            r_err_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_state       <= S_DRIVE;
                        r_busy        <= 1'b1;
                        r_vec_idx     <= '0;
                        r_hold_cnt    <= '0;
                        r_fail_mask   <= '0;
                        r_truth_table <= '0;
                        r_pass        <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_done <= 1'b0;
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_vec_idx  <= '0;
                        r_hold_cnt <= '0;
                    end else begin
                        r_a        <= r_vec_idx[1];
                        r_b        <= r_vec_idx[0];
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                        if (w_hold_last) begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    // An aborted sample leaves truth_table and fail_mask untouched.
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_vec_idx  <= '0;
                        r_hold_cnt <= '0;
                    end else begin
                        r_truth_table[10*r_vec_idx +: 10] <= y;
                        r_fail_mask <= r_fail_mask | w_diff;
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
                        if ((w_diff != '0) && (r_err_cnt != 8'hFF)) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
`endif
                        if (r_vec_idx == 2'd3) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_pass  <= ((r_fail_mask | w_diff) == '0);
                        end else begin
                            r_state    <= S_DRIVE;
                            r_vec_idx  <= w_next_vec;
                            r_hold_cnt <= '0;
                            r_a        <= w_next_vec[1];
                            r_b        <= w_next_vec[0];
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_a        <= 1'b0;
                    r_b        <= 1'b0;
                    r_vec_idx  <= '0;
                    r_hold_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a           = r_a;
    assign b           = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_mask   = r_fail_mask;
    assign truth_table = r_truth_table;
    assign vec_idx     = r_vec_idx;
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
    assign err_cnt     = r_err_cnt;
`endif

endmodule

// File: tb/tb_logic_gates_sweeper.sv
// Bench for logic_gates_sweeper: a direct gate bank (with XOR fault injection)
// on a HOLD_CYCLES=1 instance, and a one-cycle-lagged bank on a HOLD_CYCLES=3 instance.
module tb_logic_gates_sweeper;

    logic        clk;
    logic        rst;

    logic        start1, abort1;
    logic [9:0]  y1;
    logic        a1, b1, busy1, done1, pass1;
    logic [9:0]  mask1;
    logic [39:0] tt1;
    logic [1:0]  vec1;

    logic        start3, abort3;
    logic [9:0]  y3;
    logic        a3, b3, busy3, done3, pass3;
    logic [9:0]  mask3;
    logic [39:0] tt3;
    logic [1:0]  vec3;

`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
    logic [7:0]  err1, err3;
`endif

    logic [9:0]  xor_kill;
    int          checks;
    int          errors;
    logic [50:0] exp_q[$];

    localparam logic [39:0] TT_GOOD = {10'h323, 10'h18E, 10'h24E, 10'h0F8};
    localparam logic [39:0] TT_XOR0 = {10'h323, 10'h18A, 10'h24A, 10'h0F8};

    logic_gates_sweeper #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(mask1), .truth_table(tt1), .vec_idx(vec1)
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
        , .err_cnt(err1)
`endif
    );

    logic_gates_sweeper #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .y(y3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_mask(mask3), .truth_table(tt3), .vec_idx(vec3)
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
        , .err_cnt(err3)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gate bank models
    function automatic logic [9:0] bank(input logic ia, input logic ib);
        logic [9:0] r;
        r[0] = ia & ib;
        r[1] = ia | ib;
        r[2] = ia ^ ib;
        r[3] = ~(ia & ib);
        r[4] = ~(ia | ib);
        r[5] = ~(ia ^ ib);
        r[6] = ~ia;
        r[7] = ~ib;
        r[8] = ia;
        r[9] = ib;
        return r;
    endfunction

    assign y1 = bank(a1, b1) & ~xor_kill;

    initial y3 = '0;
    always @(posedge clk) y3 <= bank(a3, b3);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else          start3 = v;
    endtask

    // driver: one full sweep; expected result goes to the scoreboard queue
    task automatic sweep(input int sel, input int exp_lat, input bit restart,
                         input logic [50:0] exp_res);
        int          lat;
        int          n_done;
        logic        d;
        logic [50:0] got;
        logic [50:0] e;
        lat    = -1;
        n_done = 0;
        exp_q.push_back(exp_res);
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int c = 1; c <= exp_lat + 6; c++) begin
            @(negedge clk);
            if (c == 1) set_start(sel, 1'b0);
            else if (restart && c == 3) set_start(sel, 1'b1);
            else if (restart && c == 4) set_start(sel, 1'b0);
            d   = (sel == 1) ? done1 : done3;
            got = (sel == 1) ? {pass1, mask1, tt1} : {pass3, mask3, tt3};
            if (d) begin
                n_done++;
                if (lat < 0) lat = c;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sweep_result", 64'(got), 64'(e));
                end
            end
        end
        check("done_latency", 64'(lat), 64'(exp_lat));
        check("done_count", 64'(n_done), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int n_done;
        checks   = 0;
        errors   = 0;
        xor_kill = '0;
        start1   = 1'b0;
        abort1   = 1'b0;
        start3   = 1'b0;
        abort3   = 1'b0;
        rst      = 1'b1;

        #1;
        check("reset_flags", {60'd0, busy1, done1, pass1, a1 | b1}, 64'd0);
        check("reset_mask", 64'(mask1), 64'd0);
        check("reset_tt", 64'(tt1), 64'd0);
        check("reset_vec", 64'(vec1), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // good bank, HOLD_CYCLES=1
        sweep(1, 9, 1'b0, {1'b1, 10'h000, TT_GOOD});
        check("idle_after_done", {61'd0, busy1, a1, b1}, 64'd0);
        check("pass_held", 64'(pass1), 64'd1);

        // XOR output stuck at 0
        xor_kill = 10'h004;
        sweep(1, 9, 1'b0, {1'b0, 10'h004, TT_XOR0});
`ifdef LOGIC_GATES_SWEEP_ERRCNT_EN
        check("err_cnt", 64'(err1), 64'd2);
`endif
        xor_kill = '0;

        // start re-asserted during DRIVE
        sweep(1, 9, 1'b1, {1'b1, 10'h000, TT_GOOD});

        // abort at first SAMPLE of vector 2
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
            if (c == 5) check("abort_drive_v2", {62'd0, a1, b1}, 64'h2);
            if (c == 6) begin
                check("abort_sample_vec", 64'(vec1), 64'd2);
                abort1 = 1'b1;
            end
            if (c == 7) abort1 = 1'b0;
        end
        check("abort_idle", {60'd0, busy1, done1, a1, b1}, 64'd0);
        check("abort_tt", 64'(tt1), 64'({10'h000, 10'h000, 10'h24E, 10'h0F8}));
        check("abort_mask_pass", {53'd0, pass1, mask1}, 64'd0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done1) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);

        // asynchronous reset mid-DRIVE of vector 1
        start1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) start1 = 1'b0;
        end
        check("rst_pre_drive_v1", {61'd0, busy1, a1, b1}, 64'h5);
        #2 rst = 1'b1;
        #1;
        check("rst_async_flags", {59'd0, busy1, done1, pass1, a1, b1}, 64'd0);
        check("rst_async_state", {22'd0, vec1, mask1, tt1}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sweep(1, 9, 1'b0, {1'b1, 10'h000, TT_GOOD});

        // HOLD_CYCLES=3 with a one-cycle-lagged bank
        sweep(3, 17, 1'b0, {1'b1, 10'h000, TT_GOOD});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
